adder_arbiter: RTL

- Shares one combinational fastAdder instance (32-bit, carry-compressed) between NREQ requesters.
- Each requester streams a multi-word addition as beats, least-significant word first.
- The block chains Cout of each beat into Cin of the next beat internally, so wide adds (64/96/128-bit) run on the single 32-bit datapath.
- It sits between requester FIFOs and the adder. The result goes out through one registered valid/ready response port tagged with requester id.

---
 rtl/adder_arb_pkg.sv | 30 +++
 rtl/adder_arbiter_rr_pick.sv | 38 +++
 rtl/adder_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// ============================================================================
// adder_arb_pkg : shared types for the carry-chaining adder arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_W      = 32;
  localparam int DEF_BEAT_W = 3;
  localparam int ID_W       = $clog2(DEF_NREQ);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_W-1:0]      sum;
    logic                  cout;
    logic                  ovf;
    logic [ID_W-1:0]       id;
    logic [DEF_BEAT_W-1:0] beat;
    logic                  last;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin first-one search starting at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0] w_k;

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_k >= (IDX_W+1)'(N)) begin
        w_k = w_k - (IDX_W+1)'(N);
      end
      if (req[w_k[IDX_W-1:0]]) begin
        idx   = w_k[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter : shares one external 32-bit adder between NREQ beat streams,
//                 chaining carry between beats of a locked packet
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int W      = DEF_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ-1:0]          req_last,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  output logic                     add_cin,
  input  logic [W-1:0]             add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_ovf,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [BEAT_W-1:0]        rsp_beat,
  output logic                     rsp_last,
  output logic                     busy
);

  localparam int SEL_W = $clog2(NREQ);

  state_t            r_state;
  logic [SEL_W-1:0]  r_gnt;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_carry;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_rsp_valid;
  rsp_t              r_rsp;

  logic [W-1:0]      w_a [NREQ];
  logic [W-1:0]      w_b [NREQ];
  logic [SEL_W-1:0]  w_pick_idx;
  logic              w_pick_found;
  logic [SEL_W-1:0]  w_gnt;
  logic              w_gnt_ok;
  logic              w_first;
  logic              w_accept;
  logic              w_ovf;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[gi*W +: W];
    assign w_b[gi] = req_b[gi*W +: W];
  end

  rr_pick #(
    .N     (NREQ),
    .IDX_W (SEL_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  // Gating with rst_n keeps every output, including the combinational ones, at 0 in reset.
  assign w_gnt    = (r_state == LOCKED) ? r_gnt : w_pick_idx;
  assign w_gnt_ok = rst_n && ((r_state == LOCKED) || w_pick_found);
  assign w_first  = (r_state == IDLE) || (r_beat_cnt == '0);
  assign w_accept = w_gnt_ok && req_valid[w_gnt] && (!r_rsp_valid || rsp_ready);

  assign add_a   = w_gnt_ok ? w_a[w_gnt] : '0;
  assign add_b   = w_gnt_ok ? w_b[w_gnt] : '0;
  assign add_cin = w_gnt_ok ? (w_first ? req_cin[w_gnt] : r_carry) : 1'b0;
  assign w_ovf   = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  assign req_ready = w_accept ? (NREQ'(1) << w_gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_carry     <= 1'b0;
      r_beat_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp.sum   <= DEF_W'(add_sum);
      r_rsp.cout  <= add_cout;
      r_rsp.ovf   <= w_ovf;
      r_rsp.id    <= ID_W'(w_gnt);
      r_rsp.beat  <= DEF_BEAT_W'(r_beat_cnt);
      r_rsp.last  <= req_last[w_gnt];
      r_carry     <= add_cout;
      if (req_last[w_gnt]) begin
        r_state    <= IDLE;
        r_beat_cnt <= '0;
        r_rr_ptr   <= (w_gnt == SEL_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end else begin
        r_state    <= LOCKED;
        r_gnt      <= w_gnt;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = W'(r_rsp.sum);
  assign rsp_cout  = r_rsp.cout;
  assign rsp_ovf   = r_rsp.ovf;
  assign rsp_id    = SEL_W'(r_rsp.id);
  assign rsp_beat  = BEAT_W'(r_rsp.beat);
  assign rsp_last  = r_rsp.last;
  assign busy      = (r_state == LOCKED);

endmodule

`default_nettype wire
